// File: rtl/ads1675_pkg.sv
// Shared types and helpers for the ADS1675 serial receiver.
package ads1675_pkg;
  localparam int ADS_DATA_W = 24;
  localparam int ADS_OUT_W  = 32;

  typedef enum logic [1:0] {IDLE, SETTLE, WAIT_FALL, SHIFT} rx_state_t;

  function automatic logic [ADS_OUT_W-1:0] sext24to32(input logic [ADS_DATA_W-1:0] s);
    return {{(ADS_OUT_W-ADS_DATA_W){s[ADS_DATA_W-1]}}, s};
  endfunction
endpackage

// File: rtl/ads1675_shifter.sv
// MSB-first frame shifter: captures DATA_W bits starting in the start cycle.
module ads1675_shifter #(
  parameter int DATA_W = 24
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic              abort,
  input  logic              din,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data
);
  localparam int CW = $clog2(DATA_W);

  logic [CW-1:0]     cnt;
  logic [DATA_W-2:0] sr;

  // done fires in the cycle the last bit is on din; data already includes it
  assign done = busy & (cnt == CW'(DATA_W-1));
  assign data = {sr, din};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      busy <= 1'b0;
      cnt  <= '0;
      sr   <= '0;
    end else if (abort) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (busy) begin
      sr <= data[DATA_W-2:0];
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CW'(1);
      sr   <= data[DATA_W-2:0];
    end
  end
endmodule

// File: rtl/ads1675_rx.sv
// ADS1675 DRDY/DOUT receiver to AXI-Stream with settle discard and error flags.
// Optional ADS1675_RX_TEST_PATTERN_EN adds test_mode (counter words instead of dout).
module ads1675_rx
  import ads1675_pkg::*;
#(
  parameter int DATA_W    = 24,
  parameter int OUT_W     = 32,
  parameter int DISCARD_N = 50,
  parameter int CNT_W     = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             en,
  input  logic             drdy,
  input  logic             dout,
`ifdef ADS1675_RX_TEST_PATTERN_EN
  input  logic             test_mode,
`endif
  output logic [OUT_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             overflow,
  output logic             frame_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] drop_cnt
);
  localparam int DISC_W = (DISCARD_N > 1) ? $clog2(DISCARD_N) : 1;

  rx_state_t         state, nstate;
  logic              drdy_q, fall, rise;
  logic [DISC_W-1:0] disc_cnt;
  logic              disc_inc, disc_clr;
  logic              sh_start, sh_abort, sh_busy, sh_done;
  logic [DATA_W-1:0] sh_data, word;
  logic [OUT_W-1:0]  word_x;
  logic              frame_ok, abort_rise, ferr_set, emit, load, drop;

  assign fall       = drdy_q & ~drdy;
  assign rise       = ~drdy_q & drdy;
  assign frame_ok   = sh_done & en;
  // a rise coinciding with the last bit still completes the frame
  assign abort_rise = rise & sh_busy & ~sh_done;
  assign sh_abort   = ~en | abort_rise;
  assign ferr_set   = abort_rise & en & (state == SHIFT);
  assign emit       = frame_ok & (state == SHIFT);
  assign load       = emit & (~m_axis_tvalid | m_axis_tready);
  assign drop       = emit & m_axis_tvalid & ~m_axis_tready;

  ads1675_shifter #(.DATA_W(DATA_W)) u_shifter (
    .aclk    (aclk),
    .aresetn (aresetn),
    .start   (sh_start),
    .abort   (sh_abort),
    .din     (dout),
    .busy    (sh_busy),
    .done    (sh_done),
    .data    (sh_data)
  );

  always_comb begin
    nstate   = state;
    sh_start = 1'b0;
    disc_inc = 1'b0;
    disc_clr = 1'b0;
    case (state)
      IDLE: if (en) begin
        nstate   = SETTLE;
        disc_clr = 1'b1;
      end
      SETTLE: begin
        if (DISCARD_N == 0) begin
          // nothing to discard: act as WAIT_FALL so an immediate fall is not lost
          if (fall) begin
            sh_start = 1'b1;
            nstate   = SHIFT;
          end else begin
            nstate = WAIT_FALL;
          end
        end else begin
          sh_start = fall & ~sh_busy;
          if (frame_ok) begin
            if (disc_cnt == DISC_W'(DISCARD_N-1)) nstate = WAIT_FALL;
            else disc_inc = 1'b1;
          end
        end
      end
      WAIT_FALL: if (fall) begin
        sh_start = 1'b1;
        nstate   = SHIFT;
      end
      SHIFT: if (frame_ok | abort_rise) nstate = WAIT_FALL;
      default: nstate = IDLE;
    endcase
    if (!en) nstate = IDLE;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      drdy_q   <= 1'b0;
      disc_cnt <= '0;
    end else begin
      state  <= nstate;
      drdy_q <= drdy;
      if (disc_clr)      disc_cnt <= '0;
      else if (disc_inc) disc_cnt <= disc_cnt + 1'b1;
    end
  end

`ifdef ADS1675_RX_TEST_PATTERN_EN
  logic [DATA_W-1:0] tp_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)           tp_cnt <= '0;
    else if (state == IDLE) tp_cnt <= '0;
    else if (load)          tp_cnt <= tp_cnt + 1'b1;
  end

  assign word = test_mode ? tp_cnt : sh_data;
`else
  assign word = sh_data;
`endif

  if (DATA_W == ADS_DATA_W && OUT_W == ADS_OUT_W) begin : g_sx_fixed
    assign word_x = sext24to32(word);
  end else begin : g_sx_gen
    assign word_x = {{(OUT_W-DATA_W){word[DATA_W-1]}}, word};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      overflow      <= 1'b0;
      frame_err     <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      if (load) begin
        m_axis_tdata  <= word_x;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      overflow  <= drop | (overflow & ~err_clr);
      frame_err <= ferr_set | (frame_err & ~err_clr);
      if (drop)
        drop_cnt <= err_clr ? CNT_W'(1) : ((&drop_cnt) ? drop_cnt : drop_cnt + 1'b1);
      else if (err_clr)
        drop_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_ads1675_rx.sv
// Directed + randomized bench for ads1675_rx with a frame-level reference model.
module tb_ads1675_rx;
  localparam int DN = 2;

  logic        aclk = 1'b0;
  logic        aresetn, en, drdy, dout, tready, err_clr;
  logic [31:0] tdata;
  logic        tvalid, overflow, frame_err;
  logic [15:0] drop_cnt;

  int          errs = 0, checks = 0;
  int          settle_left = 0;
  bit          rnd = 1'b0;
  int          tr_at = -1, en_off_at = -1;
  logic [31:0] sq[$];

  always #5 aclk = ~aclk;

  ads1675_rx #(.DATA_W(24), .OUT_W(32), .DISCARD_N(DN), .CNT_W(16)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .en            (en),
    .drdy          (drdy),
    .dout          (dout),
`ifdef ADS1675_RX_TEST_PATTERN_EN
    .test_mode     (1'b0),
`endif
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .overflow      (overflow),
    .frame_err     (frame_err),
    .err_clr       (err_clr),
    .drop_cnt      (drop_cnt)
  );

`ifdef ADS1675_RX_TEST_PATTERN_EN
  logic        en2, drdy2, tvalid2, overflow2, frame_err2;
  logic [15:0] tdata2;
  logic [7:0]  drop_cnt2;

  ads1675_rx #(.DATA_W(8), .OUT_W(16), .DISCARD_N(0), .CNT_W(8)) u_tp (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .en            (en2),
    .drdy          (drdy2),
    .dout          (dout),
    .test_mode     (1'b1),
    .m_axis_tdata  (tdata2),
    .m_axis_tvalid (tvalid2),
    .m_axis_tready (1'b1),
    .overflow      (overflow2),
    .frame_err     (frame_err2),
    .err_clr       (1'b0),
    .drop_cnt      (drop_cnt2)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Two's-complement value of the 24-bit sample, as a 32-bit word
  function automatic logic [31:0] sx(input logic [23:0] s);
    return int'($signed(s));
  endfunction

  // Reference model: frames after enable are discarded until DN have completed
  function automatic int exp_mode();
    if (settle_left > 0) begin
      settle_left--;
      return 2;
    end
    return 1;
  endfunction

  // One cycle: inputs are driven after the falling edge, outputs read there too
  task automatic step();
    @(negedge aclk);
    if (rnd) tready = ($urandom_range(0, 3) != 0);
    if (rnd && tvalid && tready) begin
      if (sq.size() == 0) chk("sb_extra", 32'd1, 32'd0);
      else chk("sb_data", tdata, sq.pop_front());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      drdy = 1'b1;
      dout = 1'b0;
    end
  endtask

  // mode: 0 unchecked, 1 emit with latency pre-check, 2 no emit, 3 emit
  task automatic frame(input logic [23:0] s, input int low, input int period, input int mode);
    for (int k = 0; k < period; k++) begin
      step();
      drdy = (k >= low);
      dout = (k < 24) ? s[5'(23-k)] : 1'b0;
      if (k == en_off_at) en = 1'b0;
      if (k == tr_at) tready = 1'b1;
      if (k == 23 && mode == 1) chk("pre_lat_vld", {31'd0, tvalid}, 32'd0);
      if (k == 24 && (mode == 1 || mode == 3)) begin
        chk("lat_vld", {31'd0, tvalid}, 32'd1);
        chk("lat_data", tdata, sx(s));
      end
      if (k == 24 && mode == 2) chk("no_emit", {31'd0, tvalid}, 32'd0);
    end
  endtask

  initial begin
    logic [23:0] v;
    aresetn = 1'b0; en = 1'b0; drdy = 1'b1; dout = 1'b0; tready = 1'b1; err_clr = 1'b0;
`ifdef ADS1675_RX_TEST_PATTERN_EN
    en2 = 1'b0; drdy2 = 1'b1;
`endif
    repeat (3) @(negedge aclk);
    chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("rst_tdata", tdata, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    aresetn = 1'b1;
    idle(2);

    // settle discard, sign extension, latency
    en = 1'b1; settle_left = DN;
    idle(3);
    frame(24'h000001, 30, 48, exp_mode());
    frame(24'h800000, 30, 48, exp_mode());
    frame(24'h7FFFFF, 30, 48, exp_mode());
    frame(24'hFFFFFE, 30, 48, exp_mode());

    // backpressure: hold word, drop the next two
    tready = 1'b0;
    frame(24'hABCDEF, 30, 48, 1);
    frame(24'h111111, 30, 48, 0);
    frame(24'h222222, 30, 48, 0);
    chk("ovf_tdata_hold", tdata, 32'hFFABCDEF);
    chk("ovf_tvalid_hold", {31'd0, tvalid}, 32'd1);
    chk("ovf_drop_cnt", {16'd0, drop_cnt}, 32'd2);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    step(); err_clr = 1'b1;
    step(); err_clr = 1'b0;
    step();
    chk("clr_overflow", {31'd0, overflow}, 32'd0);
    chk("clr_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    tready = 1'b1;
    idle(2);
    chk("drain_tvalid", {31'd0, tvalid}, 32'd0);

    // early DRDY rise aborts the frame
    frame(24'h555555, 10, 48, 2);
    chk("ferr_set", {31'd0, frame_err}, 32'd1);
    frame(24'h123456, 30, 48, 1);
    chk("ferr_sticky", {31'd0, frame_err}, 32'd1);
    step(); err_clr = 1'b1;
    step(); err_clr = 1'b0;
    step();
    chk("ferr_clr", {31'd0, frame_err}, 32'd0);

    // en drops mid-frame, then re-enable restarts the discard
    en_off_at = 12;
    frame(24'h3C3C3C, 30, 48, 2);
    en_off_at = -1;
    chk("enoff_ferr", {31'd0, frame_err}, 32'd0);
    idle(2);
    en = 1'b1; settle_left = DN;
    idle(3);
    frame(24'h010203, 30, 48, exp_mode());
    frame(24'h040506, 30, 48, exp_mode());
    frame(24'h070809, 30, 48, exp_mode());

    // completion in the same cycle as accept: reload, no drop
    tready = 1'b0;
    frame(24'h0F0F0F, 30, 48, 1);
    tr_at = 23;
    frame(24'hF0F0F0, 30, 48, 3);
    tr_at = -1;
    chk("same_cyc_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    chk("same_cyc_overflow", {31'd0, overflow}, 32'd0);

    // random data, random tready
    rnd = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      v = 24'($urandom);
      sq.push_back(sx(v));
      frame(v, 30, 48, 0);
    end
    idle(60);
    rnd = 1'b0; tready = 1'b1;
    chk("sb_empty", sq.size(), 32'd0);
    chk("rnd_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    chk("rnd_overflow", {31'd0, overflow}, 32'd0);

`ifdef ADS1675_RX_TEST_PATTERN_EN
    begin
      int n;
      logic [7:0] nb;
      n = 0;
      en2 = 1'b1;
      repeat (3) @(negedge aclk);
      for (int f = 0; f < 140; f++) begin
        for (int k = 0; k < 12; k++) begin
          @(negedge aclk);
          drdy2 = (k >= 8);
          if (tvalid2) begin
            nb = n[7:0];
            chk("tp_word", {16'd0, tdata2}, {16'd0, {8{nb[7]}}, nb});
            n++;
          end
        end
      end
      chk("tp_count", n, 32'd140);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
